// File: rtl/rsa_ct_serializer.sv
// Byte serializer for completed RSA ciphertexts: captures on the ct_valid rising edge and streams
// the ciphertext out over valid/ready. Define RSA_SER_CRC_EN to append a CRC-8 trailer byte.
module rsa_ct_serializer #(
    parameter int WIDTH     = 256,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ct_in,
    input  logic             ct_valid,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic             overflow
);
    localparam int NBYTES = WIDTH / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

`ifdef RSA_SER_CRC_EN
    typedef enum logic [1:0] {IDLE, SEND, CRC} state_t;
`else
    typedef enum logic {IDLE, SEND} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CW-1:0]    cnt;
    logic             ct_valid_q;
    logic             cap;
    logic             hs;
    logic             last_ct;

    // The byte on the wire always sits at the leading end of shreg; advancing drops it.
    function automatic logic [7:0] lead_byte(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1 -: 8] : v[7:0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? (v << 8) : (v >> 8);
    endfunction

`ifdef RSA_SER_CRC_EN
    logic [7:0] crc;

    // CRC-8, poly 0x07, MSB-first, init 0, no reflection or final XOR.
    function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in ^ d;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction
`endif

    assign cap        = ct_valid & ~ct_valid_q;
    assign hs         = m_valid & m_ready;
    assign last_ct    = (cnt == CW'(NBYTES - 1));
    assign shreg_next = advance(shreg);

    // NOTE: every register here updates with <= so all reads in this block see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            // NOTE: the frame buffer is a plain register, so it is cleared like any other state.
            shreg      <= '0;
            cnt        <= '0;
            ct_valid_q <= 1'b0;
            m_data     <= 8'h00;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
`ifdef RSA_SER_CRC_EN
            crc        <= 8'h00;
`endif
        end else begin
            ct_valid_q <= ct_valid;

            // A new result arriving while a frame is still owned (even on its final beat) is lost.
            if (cap && state != IDLE)
                overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (cap) begin
                        shreg   <= ct_in;
                        m_data  <= lead_byte(ct_in);
                        m_valid <= 1'b1;
`ifdef RSA_SER_CRC_EN
                        m_last  <= 1'b0;
                        crc     <= 8'h00;
`else
                        m_last  <= (NBYTES == 1);
`endif
                        busy    <= 1'b1;
                        cnt     <= '0;
                        state   <= SEND;
                    end
                end

                SEND: begin
                    if (hs) begin
`ifdef RSA_SER_CRC_EN
                        crc <= crc8_byte(crc, m_data);
`endif
                        if (last_ct) begin
`ifdef RSA_SER_CRC_EN
                            m_data <= crc8_byte(crc, m_data);
                            m_last <= 1'b1;
                            state  <= CRC;
`else
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            busy    <= 1'b0;
                            state   <= IDLE;
`endif
                        end else begin
                            cnt    <= cnt + 1'b1;
                            shreg  <= shreg_next;
                            m_data <= lead_byte(shreg_next);
`ifdef RSA_SER_CRC_EN
                            m_last <= 1'b0;
`else
                            m_last <= (cnt == CW'(NBYTES - 2));
`endif
                        end
                    end
                end

`ifdef RSA_SER_CRC_EN
                CRC: begin
                    if (hs) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_ct_serializer.sv
// Directed bench for rsa_ct_serializer: one MSB-first and one LSB-first instance share stimulus;
// frame vectors come from a table, held-valid and mid-frame reset are hand-written sequences.
module tb_rsa_ct_serializer;
    localparam int W  = 256;
    localparam int NB = W / 8;
`ifdef RSA_SER_CRC_EN
    localparam int FLEN = NB + 1;
`else
    localparam int FLEN = NB;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] ct_in;
    logic         ct_valid;
    logic         m_ready;
    logic [7:0]   m_data_m, m_data_l;
    logic         m_valid_m, m_valid_l, m_last_m, m_last_l;
    logic         busy_m, busy_l, ovf_m, ovf_l;

    always #5 clk = ~clk;

    rsa_ct_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .ct_in(ct_in), .ct_valid(ct_valid),
        .m_data(m_data_m), .m_valid(m_valid_m), .m_ready(m_ready),
        .m_last(m_last_m), .busy(busy_m), .overflow(ovf_m)
    );

    rsa_ct_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .ct_in(ct_in), .ct_valid(ct_valid),
        .m_data(m_data_l), .m_valid(m_valid_l), .m_ready(m_ready),
        .m_last(m_last_l), .busy(busy_l), .overflow(ovf_l)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] ct;
        logic [3:0]   pat;        // m_ready pattern, MSB applied first, repeating
        int           glitch_at;  // fire a second ct_valid edge after this many bytes (-1: never)
        logic         exp_ovf;
        logic         crc_chk;
        logic [7:0]   exp_crc;
        logic [7:0]   exp_first_m;
        logic [7:0]   exp_first_l;
    } vec_t;

    logic [7:0] got_m [FLEN];
    logic [7:0] got_l [FLEN];
    logic       lst_m [FLEN];
    logic       lst_l [FLEN];
    int         n_m, n_l;

    // Pulse ct_valid for one cycle, then collect bytes from both instances until both frames
    // finish, abort_at bytes are accepted on the MSB instance, or the cycle budget runs out.
    task automatic run_frame(input logic [W-1:0] ct, input logic [3:0] pat,
                             input int glitch_at, input int abort_at);
        int         cyc = 0;
        logic       glitched = 1'b0;
        logic       stall = 1'b0;
        logic [7:0] held = 8'h00;
        n_m = 0;
        n_l = 0;
        @(posedge clk); #1;
        ct_in    = ct;
        ct_valid = 1'b1;
        check("no_valid_before_edge", 32'(m_valid_m), 32'd0);
        @(posedge clk); #1;
        ct_valid = 1'b0;
        check("first_valid", 32'(m_valid_m), 32'd1);
        check("busy_in_frame", 32'(busy_m), 32'd1);
        while ((n_m < FLEN || n_l < FLEN) && cyc < 400) begin
            if (n_m == abort_at) break;
            m_ready  = pat[3 - (cyc % 4)];
            ct_valid = (n_m == glitch_at) && !glitched;
            if (ct_valid) begin
                glitched = 1'b1;
                ct_in    = ~ct;
            end
            @(negedge clk);
            if (stall) begin
                check("stall_data_hold", 32'(m_data_m), 32'(held));
                check("stall_valid_hold", 32'(m_valid_m), 32'd1);
            end
            if (m_valid_m && m_ready && n_m < FLEN) begin
                got_m[n_m] = m_data_m;
                lst_m[n_m] = m_last_m;
                n_m++;
                stall = 1'b0;
            end else begin
                stall = m_valid_m;
                held  = m_data_m;
            end
            if (m_valid_l && m_ready && n_l < FLEN) begin
                got_l[n_l] = m_data_l;
                lst_l[n_l] = m_last_l;
                n_l++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        ct_valid = 1'b0;
        m_ready  = 1'b0;
        if (abort_at < 0) begin
            check("frame_len_m", 32'(n_m), 32'(FLEN));
            check("frame_len_l", 32'(n_l), 32'(FLEN));
        end
    endtask

    task automatic compare_frame(input vec_t v);
        for (int k = 0; k < NB; k++) begin
            check($sformatf("byte_msb[%0d]", k), 32'(got_m[k]), 32'(v.ct[W-1-8*k -: 8]));
            check($sformatf("byte_lsb[%0d]", k), 32'(got_l[k]), 32'(v.ct[8*k +: 8]));
            check($sformatf("last_msb[%0d]", k), 32'(lst_m[k]), 32'(k == FLEN - 1));
            check($sformatf("last_lsb[%0d]", k), 32'(lst_l[k]), 32'(k == FLEN - 1));
        end
        check("first_byte_msb", 32'(got_m[0]), 32'(v.exp_first_m));
        check("first_byte_lsb", 32'(got_l[0]), 32'(v.exp_first_l));
`ifdef RSA_SER_CRC_EN
        check("crc_last_msb", 32'(lst_m[NB]), 32'd1);
        check("crc_last_lsb", 32'(lst_l[NB]), 32'd1);
        if (v.crc_chk)
            check("crc_byte", 32'(got_m[NB]), 32'(v.exp_crc));
`endif
    endtask

    logic [W-1:0] ramp;
    vec_t         vecs [5];
    int           hs_cnt;

    initial begin
        for (int k = 0; k < NB; k++)
            ramp[W-1-8*k -: 8] = 8'(k + 1);

        //         ct          pat      glitch ovf   crc?  crc    1st_m  1st_l
        vecs[0] = '{ramp,      4'b1111, -1,    1'b0, 1'b0, 8'h00, 8'h01, 8'h20};
        vecs[1] = '{ramp,      4'b1001, -1,    1'b0, 1'b0, 8'h00, 8'h01, 8'h20};
        vecs[2] = '{'0,        4'b1111, -1,    1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{W'(1),     4'b1101, -1,    1'b0, 1'b1, 8'h07, 8'h00, 8'h01};
        vecs[4] = '{ramp,      4'b1111, 10,    1'b1, 1'b0, 8'h00, 8'h01, 8'h20};

        reset    = 1'b1;
        ct_valid = 1'b0;
        m_ready  = 1'b0;
        ct_in    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", 32'(m_valid_m), 32'd0);
        check("rst_m_last", 32'(m_last_m), 32'd0);
        check("rst_m_data", 32'(m_data_m), 32'd0);
        check("rst_busy", 32'(busy_m), 32'd0);
        check("rst_overflow", 32'(ovf_m), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // ct_valid held high for 50 cycles: exactly one frame, no overflow.
        hs_cnt   = 0;
        ct_in    = ramp;
        ct_valid = 1'b1;
        m_ready  = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c == 50) ct_valid = 1'b0;
            @(negedge clk);
            if (m_valid_m && m_ready) hs_cnt++;
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        check("held_valid_bytes", 32'(hs_cnt), 32'(FLEN));
        check("held_valid_ovf", 32'(ovf_m), 32'd0);
        check("held_valid_busy", 32'(busy_m), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].ct, vecs[i].pat, vecs[i].glitch_at, -1);
            @(negedge clk);
            check("end_m_valid", 32'(m_valid_m), 32'd0);
            check("end_m_last", 32'(m_last_m), 32'd0);
            check("end_busy", 32'(busy_m), 32'd0);
            compare_frame(vecs[i]);
            repeat (10) @(posedge clk);
            #1;
            check($sformatf("overflow_vec%0d", i), 32'(ovf_m), 32'(vecs[i].exp_ovf));
        end

        // Reset after five bytes: the frame and the sticky overflow both vanish.
        run_frame(ramp, 4'b1111, -1, 5);
        check("abort_count", 32'(n_m), 32'd5);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_m_valid", 32'(m_valid_m), 32'd0);
        check("abort_busy", 32'(busy_m), 32'd0);
        check("abort_overflow", 32'(ovf_m), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_quiet", 32'(m_valid_m), 32'd0);
        end
        run_frame(ramp, 4'b1111, -1, -1);
        compare_frame(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rsa_ct_serializer.md
Name: rsa_ct_serializer

Overview:
Downstream stage of the RSA encrypt wrapper. It captures each completed 256-bit ciphertext on the encrypt block's valid indication and streams it out as bytes over a valid/ready interface toward the secure-link transmit path. It provides backpressure tolerance, a last-byte marker, a busy flag, and sticky overflow detection for results dropped while a transfer is in progress.

Parameters:
WIDTH, 256, ciphertext width in bits; must be a multiple of 8 (NBYTES = WIDTH/8).
MSB_FIRST, 1, 1 = byte WIDTH-1:WIDTH-8 sent first; 0 = byte 7:0 sent first.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
ct_in  input  WIDTH  ciphertext from encrypt output c
ct_valid  input  1  encrypt valid output; level or pulse
m_data  output  8  serialized byte
m_valid  output  1  m_data holds a valid byte
m_ready  input  1  downstream accepts the byte
m_last  output  1  high with the final byte of the frame
busy  output  1  a frame is held or being sent
overflow  output  1  sticky: a ciphertext was dropped

Behaviour:
- Reset (clk, reset synchronous, active-high): state=IDLE, m_valid=0, m_last=0, m_data=0, busy=0, overflow=0, byte counter=0, ct_valid_q=0, shift register=0. Reset asserted mid-frame aborts the frame immediately; no partial bytes follow.
- Capture event: cap = ct_valid & ~ct_valid_q (rising edge). ct_valid_q <= ct_valid every cycle. ct_valid held high produces exactly one capture.
- States: IDLE, SEND (plus CRC when the optional feature is enabled).
- IDLE: on cap, latch ct_in into the shift register, clear the counter, set busy=1, go to SEND. m_valid rises the cycle after cap, giving a latency of 1 cycle from the ct_valid edge to the first byte.
- SEND: m_valid=1 and m_data = current byte. A handshake is m_valid & m_ready. On a handshake, the counter increments and the next byte is presented the following cycle. There is no bubble between bytes under continuous m_ready.
- Without a handshake, m_data, m_valid and m_last hold stable. m_valid never drops before the handshake.
- m_last=1 only while the counter is NBYTES-1.
- On the final handshake: go to IDLE. m_valid, m_last and busy all clear the next cycle.
- Overflow: a cap while state != IDLE drops that ciphertext and sets overflow=1, which stays set until reset. This includes a cap in the same cycle as the final handshake. The frame in progress is unaffected.
- Byte order:
  - MSB_FIRST=1: byte k = ct_in[WIDTH-1-8k -: 8].
  - MSB_FIRST=0: byte k = ct_in[8k +: 8].
- A full frame with m_ready held high spans NBYTES cycles of m_valid.

Optional Feature:
RSA_SER_CRC_EN:
- Defined: after the last ciphertext byte is accepted, the block enters CRC and sends one extra byte.
  - That byte is CRC-8 over the NBYTES bytes in transmit order: polynomial 0x07, init 0x00, no reflection, no final XOR.
  - m_last moves to the CRC byte and is low on all ciphertext bytes.
  - The CRC is updated on each ciphertext handshake.
  - The frame is NBYTES+1 bytes long; backpressure rules are unchanged.
- Undefined: there is no CRC state or logic, and the frame is exactly NBYTES bytes.

Test Plan:
1. Frame order: ct_in = 0x0102…1F20 (bytes 01..20), MSB_FIRST=1, m_ready=1, one-cycle ct_valid pulse -> m_valid rises next cycle; bytes 0x01..0x20 on 32 consecutive cycles; m_last only on 0x20; busy clears the cycle after.
2. Backpressure: same frame, m_ready toggling 1,0,0,1,… -> every byte appears exactly once, in order; m_data is stable through stalls; no lost or duplicated bytes.
3. Held valid / overflow:
   - ct_valid held high for 50 cycles -> exactly one frame, overflow=0.
   - A second rising edge at byte 10 -> the frame completes unchanged, overflow=1 and remains 1 through a subsequent idle period.
4. Reset mid-frame: assert reset after byte 5 is accepted -> next cycle m_valid=0, busy=0, overflow=0. A new ct_valid pulse then produces a full 32-byte frame starting at byte 0.
5. LSB order: MSB_FIRST=0, ct_in as in test 1 -> bytes 0x20 down to 0x01, m_last on 0x01.
6. CRC (RSA_SER_CRC_EN):
   - ct_in = 0 -> 33 bytes, final byte 0x00 with m_last.
   - ct_in = 1 (MSB_FIRST=1) -> final byte 0x07.
